// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game flow controller.
// IR command words, screen states and static screen bitmaps.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [31:0] CMD_UP    = 32'h20DF6A95;
  localparam logic [31:0] CMD_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] CMD_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] CMD_RIGHT = 32'h20DF9A65;
  localparam logic [31:0] CMD_OK    = 32'h20DF22DD;

  localparam logic [255:0] START_GRID = {8{32'h0FF0_8001}};
  localparam logic [255:0] END_GRID   = {8{32'h8181_7E7E}};

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle between the sequencer and IR, game core, pos2grid, display.
// master drives the sequencer inputs; slave is the sequencer side.
interface screen_sequencer_if;
  logic [31:0]  ir_word;
  logic         ir_valid;
  logic         game_tick;
  logic         game_over;
  logic         food_eaten;
  logic [15:0]  row_data;
  logic [3:0]   row_idx;
  logic [255:0] disp_grid;
  logic         game_rst;
  logic         game_en;
  logic [7:0]   score;
  logic [7:0]   high_score;
  logic [1:0]   state;

  modport master (
    output ir_word, ir_valid, game_tick,
    output game_over, food_eaten, row_data,
    input  row_idx, disp_grid, game_rst,
    input  game_en, score, high_score, state
  );

  modport slave (
    input  ir_word, ir_valid, game_tick,
    input  game_over, food_eaten, row_data,
    output row_idx, disp_grid, game_rst,
    output game_en, score, high_score, state
  );
endinterface

// File: rtl/frame_scanner.sv
// Scans pos2grid one row per cycle into a shadow buffer and commits
// a whole frame when the last row is captured.
module frame_scanner
  import snake_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  i_row_data,
  input  logic         i_commit_en,
  input  logic         i_clear,
  output logic [3:0]   o_row_idx,
  output logic [255:0] o_frame
);

  logic [3:0]        r_row;
  logic [15:0][15:0] r_shadow;
  logic [255:0]      r_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row    <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
    end else begin
      r_row <= r_row + 4'd1;
      if (i_clear) begin
        r_shadow <= '0;
        r_frame  <= '0;
      end else begin
        r_shadow[r_row] <= i_row_data;
        // row 15 comes straight from the bus so the frame is whole
        if (i_commit_en && r_row == 4'hF)
          r_frame <= {i_row_data, r_shadow[14:0]};
      end
    end
  end

  assign o_row_idx = r_row;
  assign o_frame   = r_frame;

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: screen FSM, step gating, score keeping
// and display source selection.
module screen_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned OVER_HOLD  = 100_000_000,
  parameter int unsigned SCORE_STEP = 5
) (
  input  logic               clk,
  input  logic               reset,
  screen_sequencer_if.slave  bus
);

  localparam int unsigned HW = $clog2(OVER_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD);
  localparam logic [7:0] STEP = 8'(SCORE_STEP);

  state_t        r_state;
  state_t        w_nxt;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_score;
  logic [7:0]    r_high;
  logic          r_game_rst;
  logic          r_game_en;
  logic          w_down;
  logic          w_ok;
  logic          w_up;
  logic          w_start;
  logic          w_commit_en;
  logic [3:0]    w_row_idx;
  logic [255:0]  w_frame;

  assign w_down = bus.ir_valid && bus.ir_word == CMD_DOWN;
  assign w_ok   = bus.ir_valid && bus.ir_word == CMD_OK;
  assign w_up   = bus.ir_valid && bus.ir_word == CMD_UP;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_down) w_nxt = PLAY;
      PLAY: begin
        if (bus.game_over) w_nxt = OVER;
        else if (w_ok)     w_nxt = PAUSE;
      end
      PAUSE: if (w_ok) w_nxt = PLAY;
      OVER:  if (w_up && r_hold == HOLD_MAX) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_start     = (r_state == IDLE) && (w_nxt == PLAY);
  assign w_commit_en = (r_state == PLAY) || (r_state == PAUSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_score    <= '0;
      r_high     <= '0;
      r_game_rst <= 1'b1;
      r_game_en  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_game_rst <= (w_nxt == IDLE);
      r_game_en  <= bus.game_tick && r_state == PLAY
                    && !bus.game_over;
      // counter sits at 0 outside OVER, so entry always starts fresh
      if (r_state != OVER)
        r_hold <= '0;
      else if (r_hold != HOLD_MAX)
        r_hold <= r_hold + HW'(1);
      if (w_start)
        r_score <= '0;
      else if (r_state == PLAY && bus.food_eaten)
        r_score <= sat_add(r_score, STEP);
      if (r_state == PLAY && w_nxt == OVER && r_score > r_high)
        r_high <= r_score;
    end
  end

  frame_scanner u_scan (
    .clk         (clk),
    .reset       (reset),
    .i_row_data  (bus.row_data),
    .i_commit_en (w_commit_en),
    .i_clear     (w_start),
    .o_row_idx   (w_row_idx),
    .o_frame     (w_frame)
  );

  assign bus.disp_grid  = (r_state == IDLE) ? START_GRID :
                          (r_state == OVER) ? END_GRID : w_frame;
  assign bus.row_idx    = w_row_idx;
  assign bus.game_rst   = r_game_rst;
  assign bus.game_en    = r_game_en;
  assign bus.score      = r_score;
  assign bus.high_score = r_high;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a queue of expected values.
// OVER_HOLD is shortened to 20 cycles.
module tb_screen_sequencer;

  localparam logic [31:0] K_UP   = 32'h20DF6A95;
  localparam logic [31:0] K_DOWN = 32'h20DFEA15;
  localparam logic [31:0] K_OK   = 32'h20DF22DD;
  localparam logic [255:0] K_START = {8{32'h0FF0_8001}};
  localparam logic [255:0] K_END   = {8{32'h8181_7E7E}};

  logic clk = 1'b0;
  logic reset;
  int n_pass = 0;
  int n_total = 0;
  logic [255:0] exp_q[$];
  logic [255:0] fr;

  screen_sequencer_if sif ();

  screen_sequencer #(
    .OVER_HOLD  (20),
    .SCORE_STEP (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [3:0] r);
    return (r == 4'd3) ? 16'h8001 : {4'h5, r, ~r, 4'hC};
  endfunction

  assign sif.row_data = pat(sif.row_idx);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input logic [255:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs);
    logic [255:0] e;
    e = exp_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
  endtask

  task automatic pulse_ir(input logic [31:0] w);
    sif.ir_word  = w;
    sif.ir_valid = 1'b1;
    step(1);
    sif.ir_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sif.ir_word = '0;
    sif.ir_valid = 1'b0;
    sif.game_tick = 1'b0;
    sif.game_over = 1'b0;
    sif.food_eaten = 1'b0;
    for (int r = 0; r < 16; r++) fr[r*16 +: 16] = pat(4'(r));

    step(2);
    expect_v(256'(0));
    chk("rst_row_idx", 256'(sif.row_idx));
    reset = 1'b0;
    step(100);
    expect_v(256'(0));
    expect_v(256'(1));
    expect_v(K_START);
    expect_v(256'(0));
    expect_v(256'(0));
    chk("idle_state", 256'(sif.state));
    chk("idle_game_rst", 256'(sif.game_rst));
    chk("idle_disp", sif.disp_grid);
    chk("idle_score", 256'(sif.score));
    chk("idle_game_en", 256'(sif.game_en));

    sif.ir_word = K_DOWN;
    expect_v(256'(0));
    step(5);
    chk("held_word_no_cmd", 256'(sif.state));

    expect_v(256'(1));
    expect_v(256'(0));
    pulse_ir(K_DOWN);
    chk("down_to_play", 256'(sif.state));
    chk("play_game_rst", 256'(sif.game_rst));

    sif.game_tick = 1'b1;
    expect_v(256'(1));
    step(1);
    sif.game_tick = 1'b0;
    chk("game_en_pulse", 256'(sif.game_en));
    expect_v(256'(0));
    step(1);
    chk("game_en_drop", 256'(sif.game_en));

    for (int i = 0; i < 40; i++) begin
      if (sif.disp_grid === fr) break;
      step(1);
    end
    expect_v(256'(16'h8001));
    expect_v(fr);
    chk("frame_row3", 256'(sif.disp_grid[63:48]));
    chk("frame_full", sif.disp_grid);

    sif.food_eaten = 1'b1;
    expect_v(256'(15));
    step(3);
    sif.food_eaten = 1'b0;
    chk("score_15", 256'(sif.score));

    expect_v(256'(2));
    pulse_ir(K_OK);
    chk("ok_to_pause", 256'(sif.state));
    sif.game_tick = 1'b1;
    expect_v(256'(0));
    step(1);
    sif.game_tick = 1'b0;
    chk("pause_no_game_en", 256'(sif.game_en));
    sif.food_eaten = 1'b1;
    expect_v(256'(15));
    step(1);
    sif.food_eaten = 1'b0;
    chk("pause_food_ignored", 256'(sif.score));
    sif.game_over = 1'b1;
    expect_v(256'(2));
    step(2);
    chk("pause_over_ignored", 256'(sif.state));
    sif.game_over = 1'b0;
    expect_v(256'(1));
    pulse_ir(K_OK);
    chk("ok_to_play", 256'(sif.state));

    sif.game_over = 1'b1;
    expect_v(256'(3));
    expect_v(256'(15));
    expect_v(K_END);
    pulse_ir(K_OK);
    chk("over_priority", 256'(sif.state));
    chk("high_15", 256'(sif.high_score));
    chk("over_disp", sif.disp_grid);

    step(10);
    expect_v(256'(3));
    pulse_ir(K_UP);
    chk("up_early_10", 256'(sif.state));
    step(8);
    expect_v(256'(3));
    pulse_ir(K_UP);
    chk("up_early_19", 256'(sif.state));
    expect_v(256'(0));
    expect_v(256'(1));
    expect_v(K_START);
    expect_v(256'(15));
    pulse_ir(K_UP);
    chk("up_to_idle", 256'(sif.state));
    chk("idle_game_rst2", 256'(sif.game_rst));
    chk("idle_disp2", sif.disp_grid);
    chk("high_kept", 256'(sif.high_score));

    sif.game_over = 1'b0;
    step(2);
    expect_v(256'(1));
    expect_v(256'(0));
    pulse_ir(K_DOWN);
    chk("play2", 256'(sif.state));
    chk("score_cleared", 256'(sif.score));
    sif.food_eaten = 1'b1;
    expect_v(256'(250));
    step(50);
    chk("score_250", 256'(sif.score));
    expect_v(256'(255));
    step(1);
    chk("score_255", 256'(sif.score));
    expect_v(256'(255));
    step(1);
    sif.food_eaten = 1'b0;
    chk("score_sat", 256'(sif.score));

    sif.game_over = 1'b1;
    expect_v(256'(3));
    expect_v(256'(255));
    step(1);
    chk("over2", 256'(sif.state));
    chk("high_255", 256'(sif.high_score));
    sif.game_tick = 1'b1;
    expect_v(256'(0));
    step(1);
    sif.game_tick = 1'b0;
    chk("over_no_game_en", 256'(sif.game_en));

    for (int i = 0; i < 20; i++) begin
      if (sif.row_idx == 4'd7) break;
      step(1);
    end
    expect_v(256'(7));
    chk("at_row7", 256'(sif.row_idx));
    reset = 1'b1;
    #1;
    expect_v(256'(0));
    expect_v(256'(0));
    expect_v(256'(0));
    expect_v(256'(0));
    expect_v(256'(1));
    expect_v(K_START);
    chk("mid_rst_row", 256'(sif.row_idx));
    chk("mid_rst_state", 256'(sif.state));
    chk("mid_rst_score", 256'(sif.score));
    chk("mid_rst_high", 256'(sif.high_score));
    chk("mid_rst_game_rst", 256'(sif.game_rst));
    chk("mid_rst_disp", sif.disp_grid);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
Central game-flow controller between the IR receiver, the snake game core, pos2grid and the LED matrix driver. It sequences the start, play, pause and over screens from decoded IR commands and game events. It gates the game step tick, holds the game core in reset outside play, and keeps score and high score. It also scans pos2grid row by row into a shadow frame, committing a coherent 16x16 frame to the display once per scan.

Parameters:
OVER_HOLD, 100_000_000, cycles the OVER screen ignores input before UP is accepted (2 s at 50 MHz).
SCORE_STEP, 5, score increment per food eaten.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
ir_word  in  32  last decoded NEC word; level, valid only when ir_valid=1
ir_valid  in  1  one-cycle pulse, synchronous to clk, new ir_word available
game_tick  in  1  one-cycle pulse at game step rate
game_over  in  1  level from game core, collision detected
food_eaten  in  1  one-cycle pulse from game core
row_data  in  16  pos2grid column bits for row row_idx (combinational from row_idx)
row_idx  out  4  row currently being scanned
disp_grid  out  256  frame to matrix driver, [15:0][15:0], row-major
game_rst  out  1  synchronous reset to game core
game_en  out  1  gated step pulse to game core
score  out  8  current score, binary
high_score  out  8  best score since reset
state  out  2  current screen state

Behaviour:
- One clock; reset is asynchronous and active-high. All registers clear on reset assertion.
- Reset values: state=IDLE, game_rst=1, game_en=0, score=0, high_score=0, row_idx=0, disp_grid=START_GRID, hold counter=0.
- States (2-bit enum): IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- ir_word is compared only in cycles where ir_valid=1. A held ir_word with no pulse is never a command.
- IDLE:
  - ir_valid & word==CMD_DOWN -> PLAY.
  - On that transition, score clears and the shadow frame clears.
- PLAY:
  - game_over=1 -> OVER. This has priority over any same-cycle command.
  - Otherwise ir_valid & word==CMD_OK -> PAUSE.
- PAUSE:
  - ir_valid & word==CMD_OK -> PLAY.
  - game_over is ignored in PAUSE.
- OVER:
  - Hold counter loads 0 on entry and increments to OVER_HOLD, then saturates.
  - ir_valid & word==CMD_UP with counter==OVER_HOLD -> IDLE.
  - Earlier UP commands are dropped, not queued.
- game_rst: registered, =1 whenever next state is IDLE. It deasserts in the first PLAY cycle and stays 0 in PLAY, PAUSE and OVER.
- game_en: registered, =game_tick & state==PLAY & ~game_over. It is one cycle after game_tick, never asserted outside PLAY.
- Score:
  - On food_eaten in PLAY, score += SCORE_STEP, saturating at 255 (250+5=255, 255+5=255).
  - food_eaten outside PLAY is ignored.
  - On the PLAY->OVER transition, high_score <= max(high_score, score). The new value is visible in the first OVER cycle.
- Frame scan:
  - row_idx increments every cycle, wrapping 15->0, in all states.
  - Each cycle shadow[row_idx] <= row_data.
  - In the cycle row 15 is captured, while in PLAY or PAUSE, disp_grid <= shadow with row 15 replaced by the current row_data. Frame latency is at most 16 cycles; no torn frames.
- Static screens:
  - In IDLE, disp_grid=START_GRID.
  - In OVER, disp_grid=END_GRID.
  - Written the cycle after the state change, independent of the row scan.
- PAUSE keeps committing frames, so the display stays live but frozen because game_en=0.
- Reset mid-frame: the scan restarts at row 0 and disp_grid returns to START_GRID.

Decomposition:
- Package snake_pkg:
  - state_t enum.
  - CMD_UP=32'h20DF6A95, CMD_DOWN=32'h20DFEA15, CMD_LEFT=32'h20DF1AE5, CMD_RIGHT=32'h20DF9A65, CMD_OK=32'h20DF22DD.
  - START_GRID and END_GRID 256-bit constants.
- Sub-module frame_scanner: row_idx counter, shadow buffer, commit strobe. It has inputs clk, reset, row_data and commit_en, and outputs row_idx and frame.
- State machine, score logic and game gating stay in screen_sequencer.

Test Plan:
- Reset then idle 100 cycles -> state=0, game_rst=1, disp_grid=START_GRID, score=0. ir_word=CMD_DOWN with ir_valid=0 -> no transition.
- ir_valid pulse with CMD_DOWN -> state=1 next cycle, game_rst=0. game_tick pulses -> game_en pulses one cycle later. row_data=16'h8001 for row 3 -> disp_grid row 3 = 16'h8001 within 16 cycles.
- In PLAY, 3 food_eaten pulses -> score=15. 52 pulses -> score=255, saturated. food_eaten in PAUSE -> score unchanged.
- CMD_OK pulse in PLAY -> state=2, game_en stays 0 despite game_tick. Second CMD_OK -> state=1.
- game_over and CMD_OK in the same cycle -> state=3, not 2. high_score=score=15, disp_grid=END_GRID.
- In OVER, CMD_UP at hold count 10 (OVER_HOLD=20 in the bench) -> stays 3. CMD_UP after 20 cycles -> state=0, game_rst=1. Assert reset mid-frame at row 7 -> row_idx=0, all outputs at reset values immediately.
